// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: FSM encoding and oversampling points.
package uart_rx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is selectable.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            sync_p0 <= i_d;
            sync_p1 <= sync_p0;
        end
    end

    assign o_q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, 1 start / NB_DATA data (LSB first) / stop.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int SB_TICK     = 16,
    parameter int NB_TICK_CNT = 5
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done_tick,
    output logic               o_frame_error
);

    localparam int NB_BIT_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_TICK_CNT-1:0] S_MID  = NB_TICK_CNT'(MID_SAMPLE);
    localparam logic [NB_TICK_CNT-1:0] S_BIT  = NB_TICK_CNT'(OVERSAMPLE - 1);
    localparam logic [NB_TICK_CNT-1:0] S_STOP = NB_TICK_CNT'(SB_TICK - 1);
    localparam logic [NB_BIT_CNT-1:0]  N_LAST = NB_BIT_CNT'(NB_DATA - 1);

    logic                   rx_s;
    logic [1:0]             state;
    logic [NB_TICK_CNT-1:0] s;
    logic [NB_BIT_CNT-1:0]  n;
    logic [NB_DATA-1:0]     shreg;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_rx),
        .o_q       (rx_s)
    );

    // IDLE reacts without a tick so a start edge right after a stop is never missed.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= ST_IDLE;
            s              <= '0;
            n              <= '0;
            shreg          <= '0;
            o_data         <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_error  <= 1'b0;
        end else begin
            o_rx_done_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        s     <= '0;
                    end
                end
                ST_START: begin
                    if (i_tick) begin
                        if (s == S_MID) begin
                            if (!rx_s) begin
                                state <= ST_DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_tick) begin
                        if (s == S_BIT) begin
                            shreg <= {rx_s, shreg[NB_DATA-1:1]};
                            s     <= '0;
                            if (n == N_LAST) begin
                                state <= ST_STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (i_tick) begin
                        if (s == S_STOP) begin
                            o_data         <= shreg;
                            o_frame_error  <= ~rx_s;
                            o_rx_done_tick <= 1'b1;
                            state          <= ST_IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 1-stop instance and a 2-stop (SB_TICK=32) instance share clock, tick and reset.
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       tick;
    logic       rx1;
    logic       rx2;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       done1;
    logic       done2;
    logic       ferr1;
    logic       ferr2;

    int tcnt       = 0;
    int tick_total = 0;

    // Stand-in for the baud generator with COUNTER_LIMIT = 4: one tick every 5 clocks.
    always @(posedge clk) begin
        tcnt <= (tcnt == 4) ? 0 : tcnt + 1;
        if (tick) tick_total <= tick_total + 1;
    end
    assign tick = (tcnt == 4);

    uart_rx #(.NB_DATA(8), .SB_TICK(16), .NB_TICK_CNT(5)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx(rx1),
        .o_data(data1), .o_rx_done_tick(done1), .o_frame_error(ferr1)
    );

    uart_rx #(.NB_DATA(8), .SB_TICK(32), .NB_TICK_CNT(5)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx(rx2),
        .o_data(data2), .o_rx_done_tick(done2), .o_frame_error(ferr2)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         dcnt1 = 0;
    int         dcnt2 = 0;
    int         last_tick1 = 0;
    int         last_tick2 = 0;
    logic [7:0] q_data1[$];
    logic       q_ferr1[$];

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            dcnt1++;
            last_tick1 = tick_total;
            q_data1.push_back(data1);
            q_ferr1.push_back(ferr1);
        end
        if (done2 === 1'b1) begin
            dcnt2++;
            last_tick2 = tick_total;
        end
    end

    task automatic wait_ticks(input int k);
        int c;
        c = 0;
        while (c < k) begin
            @(posedge clk);
            if (tick) c++;
        end
        #1;
    endtask

    task automatic set_rx(input int line, input logic v);
        if (line == 1) rx1 = v;
        else rx2 = v;
    endtask

    // A low final stop bit is released after 10 ticks so the line is high by the next start check.
    task automatic send_frame(input int line, input logic [7:0] b, input logic [1:0] stop_v,
                              input int nstop, output int t0);
        set_rx(line, 1'b0);
        t0 = tick_total;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            set_rx(line, b[i]);
            wait_ticks(16);
        end
        for (int k = 0; k < nstop; k++) begin
            if (k == nstop - 1 && !stop_v[k]) begin
                set_rx(line, 1'b0);
                wait_ticks(10);
                set_rx(line, 1'b1);
                wait_ticks(6);
            end else begin
                set_rx(line, stop_v[k]);
                wait_ticks(16);
            end
        end
        set_rx(line, 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        rx1   = 1'b1;
        rx2   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data1 !== 8'h00) begin n_bad++; $display("FAIL reset_data1: got %h expected 00", data1); end
        n_cmp++; if (done1 !== 1'b0)  begin n_bad++; $display("FAIL reset_done1: got %b expected 0", done1); end
        n_cmp++; if (ferr1 !== 1'b0)  begin n_bad++; $display("FAIL reset_ferr1: got %b expected 0", ferr1); end
        n_cmp++; if (data2 !== 8'h00) begin n_bad++; $display("FAIL reset_data2: got %h expected 00", data2); end
        rst_n = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_basic;
        int t0;
        int d0;
        d0 = dcnt1;
        send_frame(1, 8'hA5, 2'b11, 1, t0);
        wait_ticks(16);
        n_cmp++; if (dcnt1 - d0 !== 1)         begin n_bad++; $display("FAIL basic_pulses: got %0d expected 1", dcnt1 - d0); end
        n_cmp++; if (data1 !== 8'hA5)          begin n_bad++; $display("FAIL basic_data: got %h expected a5", data1); end
        n_cmp++; if (ferr1 !== 1'b0)           begin n_bad++; $display("FAIL basic_ferr: got %b expected 0", ferr1); end
        n_cmp++; if (last_tick1 - t0 !== 152)  begin n_bad++; $display("FAIL basic_latency: got %0d expected 152 ticks", last_tick1 - t0); end
    endtask

    task automatic test_frame_error;
        int t0;
        int d0;
        d0 = dcnt1;
        send_frame(1, 8'h3C, 2'b00, 1, t0);
        wait_ticks(16);
        n_cmp++; if (dcnt1 - d0 !== 1) begin n_bad++; $display("FAIL ferr_pulses: got %0d expected 1", dcnt1 - d0); end
        n_cmp++; if (data1 !== 8'h3C)  begin n_bad++; $display("FAIL ferr_data: got %h expected 3c", data1); end
        n_cmp++; if (ferr1 !== 1'b1)   begin n_bad++; $display("FAIL ferr_flag: got %b expected 1", ferr1); end
        d0 = dcnt1;
        send_frame(1, 8'h81, 2'b11, 1, t0);
        wait_ticks(16);
        n_cmp++; if (dcnt1 - d0 !== 1) begin n_bad++; $display("FAIL ferr_next_pulses: got %0d expected 1", dcnt1 - d0); end
        n_cmp++; if (data1 !== 8'h81)  begin n_bad++; $display("FAIL ferr_next_data: got %h expected 81", data1); end
        n_cmp++; if (ferr1 !== 1'b0)   begin n_bad++; $display("FAIL ferr_next_flag: got %b expected 0", ferr1); end
    endtask

    task automatic test_glitch;
        int d0;
        d0 = dcnt1;
        rx1 = 1'b0;
        wait_ticks(4);
        rx1 = 1'b1;
        wait_ticks(24);
        n_cmp++; if (dcnt1 - d0 !== 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d expected 0", dcnt1 - d0); end
        n_cmp++; if (data1 !== 8'h81)  begin n_bad++; $display("FAIL glitch_data: got %h expected 81", data1); end
        n_cmp++; if (dut1.state !== 2'b00) begin n_bad++; $display("FAIL glitch_state: got %b expected 00", dut1.state); end
    endtask

    task automatic test_back_to_back;
        int         t0;
        logic [7:0] exp_d [3];
        logic [7:0] got_d;
        logic       got_e;
        exp_d[0] = 8'h00;
        exp_d[1] = 8'hFF;
        exp_d[2] = 8'h55;
        q_data1.delete();
        q_ferr1.delete();
        for (int i = 0; i < 3; i++) send_frame(1, exp_d[i], 2'b11, 1, t0);
        wait_ticks(16);
        n_cmp++; if (q_data1.size() !== 3) begin n_bad++; $display("FAIL b2b_pulses: got %0d expected 3", q_data1.size()); end
        for (int i = 0; i < 3; i++) begin
            got_d = 8'hxx;
            got_e = 1'bx;
            if (q_data1.size() > 0) begin
                got_d = q_data1.pop_front();
                got_e = q_ferr1.pop_front();
            end
            n_cmp++; if (got_d !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_d, exp_d[i]); end
            n_cmp++; if (got_e !== 1'b0)     begin n_bad++; $display("FAIL b2b_ferr%0d: got %b expected 0", i, got_e); end
        end
    endtask

    task automatic test_reset_midframe;
        int         t0;
        int         d0;
        logic [7:0] b;
        b  = 8'hC3;
        d0 = dcnt1;
        rx1 = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx1 = b[i];
            wait_ticks(16);
        end
        rx1 = b[4];
        wait_ticks(8);
        rst_n = 1'b0;
        rx1   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data1 !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h expected 00", data1); end
        n_cmp++; if (done1 !== 1'b0)  begin n_bad++; $display("FAIL rstmid_done: got %b expected 0", done1); end
        n_cmp++; if (ferr1 !== 1'b0)  begin n_bad++; $display("FAIL rstmid_ferr: got %b expected 0", ferr1); end
        wait_ticks(4);
        rst_n = 1'b1;
        wait_ticks(32);
        n_cmp++; if (dcnt1 - d0 !== 0) begin n_bad++; $display("FAIL rstmid_aborted: got %0d pulses expected 0", dcnt1 - d0); end
        send_frame(1, 8'h5A, 2'b11, 1, t0);
        wait_ticks(16);
        n_cmp++; if (dcnt1 - d0 !== 1) begin n_bad++; $display("FAIL rstmid_next_pulses: got %0d expected 1", dcnt1 - d0); end
        n_cmp++; if (data1 !== 8'h5A)  begin n_bad++; $display("FAIL rstmid_next_data: got %h expected 5a", data1); end
    endtask

    task automatic test_two_stop;
        int t0;
        int d0;
        d0 = dcnt2;
        send_frame(2, 8'h96, 2'b11, 2, t0);
        wait_ticks(16);
        n_cmp++; if (dcnt2 - d0 !== 1)        begin n_bad++; $display("FAIL stop2_pulses: got %0d expected 1", dcnt2 - d0); end
        n_cmp++; if (data2 !== 8'h96)         begin n_bad++; $display("FAIL stop2_data: got %h expected 96", data2); end
        n_cmp++; if (ferr2 !== 1'b0)          begin n_bad++; $display("FAIL stop2_ferr: got %b expected 0", ferr2); end
        n_cmp++; if (last_tick2 - t0 !== 168) begin n_bad++; $display("FAIL stop2_latency: got %0d expected 168 ticks", last_tick2 - t0); end
        d0 = dcnt2;
        send_frame(2, 8'h69, 2'b01, 2, t0);
        wait_ticks(16);
        n_cmp++; if (dcnt2 - d0 !== 1) begin n_bad++; $display("FAIL stop2_err_pulses: got %0d expected 1", dcnt2 - d0); end
        n_cmp++; if (data2 !== 8'h69)  begin n_bad++; $display("FAIL stop2_err_data: got %h expected 69", data2); end
        n_cmp++; if (ferr2 !== 1'b1)   begin n_bad++; $display("FAIL stop2_err_flag: got %b expected 1", ferr2); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_frame_error;
        test_glitch;
        test_back_to_back;
        test_reset_midframe;
        test_two_stop;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before 3000000");
        $fatal(1, "watchdog expired");
    end

endmodule
